dm_sba_target: RTL and testbench



---
 rtl/dm_sba_target.sv | 164 ++++++++++++++++
 tb/tb_dm_sba_target.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_target.sv
// Debug-module system-bus target: single-outstanding req/gnt/r_valid slave backed by a
// small register-file RAM with programmable grant/response latency. Optional range check: DM_SBA_TARGET_ERR_EN.
module dm_sba_target #(
    parameter int unsigned          BusWidth = 32,
    parameter int unsigned          NumWords = 16,
    parameter logic [BusWidth-1:0]  BaseAddr = '0,
    parameter int unsigned          GntDelay = 0,
    parameter int unsigned          RspDelay = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_req_i,
    input  logic [BusWidth-1:0]   slave_add_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    output logic                  slave_gnt_o,
    output logic                  slave_r_valid_o,
    output logic [BusWidth-1:0]   slave_r_rdata_o,
    output logic                  slave_err_o
);

    localparam int unsigned NumBytes = BusWidth / 8;
    localparam int unsigned AddrLsb  = $clog2(NumBytes);
    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam logic [3:0]  GntLoad  = (GntDelay == 0) ? 4'd0 : 4'(GntDelay - 1);
    localparam logic [3:0]  RspLoad  = 4'(RspDelay - 1);

    // Handshake: a transfer happens on the edge where slave_req_i && slave_gnt_o; the
    // response is a one-cycle slave_r_valid_o pulse, and no grant is given until after it.
    typedef enum logic [1:0] {
        Idle    = 2'd0,
        GntWait = 2'd1,
        Resp    = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_d;
    logic                w_gnt;
    logic                w_rvalid;
    logic                w_grant;
    logic [BusWidth-1:0] w_off;
    logic [IdxW-1:0]     w_idx;
    logic                w_in_range;
    logic                w_unused;

    logic [BusWidth-1:0] r_mem [NumWords];
    logic [BusWidth-1:0] r_rdata;

    // BaseAddr is aligned to the memory size, so the offset's index bits equal the address's.
    assign w_off    = slave_add_i - BaseAddr;
    assign w_idx    = w_off[AddrLsb +: IdxW];
    assign w_unused = ^w_off;

`ifdef DM_SBA_TARGET_ERR_EN
    localparam logic [BusWidth-1:0] MemBytes = BusWidth'(NumWords * NumBytes);
    assign w_in_range = (w_off < MemBytes);
`else
    assign w_in_range = 1'b1;
`endif

    assign slave_gnt_o = w_gnt & rst_ni;
    assign w_grant     = slave_req_i & slave_gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            Idle: begin
                if (w_grant) begin
                    w_state_d = Resp;
                    w_cnt_d   = RspLoad;
                end else if (slave_req_i) begin
                    w_state_d = GntWait;
                    w_cnt_d   = GntLoad;
                end
            end
            GntWait: begin
                // Dropping req abandons the request entirely.
                if (!slave_req_i) begin
                    w_state_d = Idle;
                    w_cnt_d   = 4'd0;
                end else if (w_grant) begin
                    w_state_d = Resp;
                    w_cnt_d   = RspLoad;
                end else begin
                    w_cnt_d   = r_cnt - 4'd1;
                end
            end
            Resp: begin
                if (r_cnt == 4'd0) begin
                    w_state_d = Idle;
                    w_cnt_d   = 4'd0;
                end else begin
                    w_cnt_d   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_d = Idle;
                w_cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_gnt    = 1'b0;
        w_rvalid = 1'b0;
        unique case (r_state)
            Idle:    w_gnt    = (GntDelay == 0) && slave_req_i;
            GntWait: w_gnt    = slave_req_i && (r_cnt == 4'd0);
            Resp:    w_rvalid = (r_cnt == 4'd0);
            default: begin
                w_gnt    = 1'b0;
                w_rvalid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) r_mem[i] <= '0;
            r_rdata <= '0;
        end else if (w_grant) begin
            if (slave_we_i && w_in_range) begin
                for (int b = 0; b < NumBytes; b++) begin
                    if (slave_be_i[b]) r_mem[w_idx][b*8 +: 8] <= slave_wdata_i[b*8 +: 8];
                end
            end
            r_rdata <= (!slave_we_i && w_in_range) ? r_mem[w_idx] : '0;
        end
    end

    assign slave_r_valid_o = w_rvalid;
    assign slave_r_rdata_o = w_rvalid ? r_rdata : '0;

`ifdef DM_SBA_TARGET_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_grant) begin
            r_err <= ~w_in_range;
        end
    end

    assign slave_err_o = w_rvalid & r_err;
`else
    assign slave_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dm_sba_target.sv
// Bench for dm_sba_target: a default-latency instance (dut 0) and a GntDelay=3/RspDelay=2
// instance (dut 1), directed transactions, and a response scoreboard.
module tb_dm_sba_target;

`ifdef DM_SBA_TARGET_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        req    [2];
  logic        we     [2];
  logic [31:0] add    [2];
  logic [31:0] wdata  [2];
  logic [3:0]  be     [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  dm_sba_target u_dut0 (
    .clk_i           (clk),
    .rst_ni          (rst_n[0]),
    .slave_req_i     (req[0]),
    .slave_add_i     (add[0]),
    .slave_we_i      (we[0]),
    .slave_wdata_i   (wdata[0]),
    .slave_be_i      (be[0]),
    .slave_gnt_o     (gnt[0]),
    .slave_r_valid_o (rvalid[0]),
    .slave_r_rdata_o (rdata[0]),
    .slave_err_o     (err[0])
  );

  dm_sba_target #(.GntDelay(3), .RspDelay(2)) u_dut1 (
    .clk_i           (clk),
    .rst_ni          (rst_n[1]),
    .slave_req_i     (req[1]),
    .slave_add_i     (add[1]),
    .slave_we_i      (we[1]),
    .slave_wdata_i   (wdata[1]),
    .slave_be_i      (be[1]),
    .slave_gnt_o     (gnt[1]),
    .slave_r_valid_o (rvalid[1]),
    .slave_r_rdata_o (rdata[1]),
    .slave_err_o     (err[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one complete transaction, checking grant and response latency
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input logic [31:0] erd, input logic ee,
                     input int gl, input int rl);
    int cyc;
    bit got;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; add[d] = a; wdata[d] = wd; be[d] = b;
    cyc = 0;
    got = 1'b0;
    forever begin
      #1;
      if (gnt[d] === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (cyc >= 40) break;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("gnt_latency_dut%0d", d), got ? cyc : -1, gl);
    if (!got) begin
      req[d] = 1'b0;
      return;
    end
    if (d == 0) exp_q0.push_back({ee, erd});
    else        exp_q1.push_back({ee, erd});
    cyc = 0;
    got = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      // request stays high with junk payload: must be ignored and never granted
      add[d] = ~a; wdata[d] = ~wd; we[d] = ~w; be[d] = ~b;
      #1;
      check($sformatf("no_gnt_in_resp_dut%0d", d), gnt[d], 1'b0);
      if (rvalid[d] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("rsp_latency_dut%0d", d), got ? cyc : -1, rl);
    req[d] = 1'b0;
  endtask

  // request on dut1 that is dropped before its grant
  task automatic abandon(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; add[1] = a; wdata[1] = wd; be[1] = 4'hF;
    #1 check("abandon_gnt_c0", gnt[1], 1'b0);
    @(negedge clk);
    req[1] = 1'b0;
    #1 check("abandon_gnt_c1", gnt[1], 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("abandon_idle_gnt", gnt[1], 1'b0);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        if (rvalid[d] === 1'b1) begin
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rvalid_dut%0d: got r_valid=1, expected 0 (t=%0t)", d, $time);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("rsp_rdata_dut%0d", d), rdata[d], e[31:0]);
            check($sformatf("rsp_err_dut%0d", d), err[d], e[32]);
          end
        end else begin
          check($sformatf("quiet_outputs_dut%0d", d), {err[d], rdata[d]}, 33'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
      add[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    // gnt must stay low under reset even with req asserted
    req[0] = 1'b1;
    @(negedge clk);
    #1;
    check("rst_gnt", gnt[0], 1'b0);
    check("rst_rvalid", rvalid[0], 1'b0);
    check("rst_rdata", rdata[0], 32'h0);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // default latency: write/read, byte-enable merge, ignored low address bits
    txn(0, 1'b1, 32'h8,  32'hDEADBEEF, 4'hF,    32'h0,        1'b0, 0, 1);
    txn(0, 1'b0, 32'h8,  32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 0, 1);
    txn(0, 1'b1, 32'h4,  32'h11223344, 4'hF,    32'h0,        1'b0, 0, 1);
    txn(0, 1'b1, 32'h4,  32'hAABBCCDD, 4'b0101, 32'h0,        1'b0, 0, 1);
    txn(0, 1'b0, 32'h4,  32'h0,        4'h0,    32'h11BB33DD, 1'b0, 0, 1);
    txn(0, 1'b0, 32'hB,  32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 0, 1);
    txn(0, 1'b0, 32'h0,  32'h0,        4'h0,    32'h0,        1'b0, 0, 1);

    // out-of-range access (error build) or alias of word 0 (default build)
    txn(0, 1'b1, 32'h40, 32'h55AA55AA, 4'hF, 32'h0, ErrEn, 0, 1);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, ErrEn ? 32'h0 : 32'h55AA55AA, ErrEn, 0, 1);
    txn(0, 1'b0, 32'h0,  32'h0, 4'h0, ErrEn ? 32'h0 : 32'h55AA55AA, 1'b0,  0, 1);

    // GntDelay=3 / RspDelay=2
    txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 3, 2);
    abandon(32'h10, 32'h12345678);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 3, 2);

    // reset while in Resp after a write grant
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; add[1] = 32'h10; wdata[1] = 32'h0BADF00D; be[1] = 4'hF;
    repeat (3) @(negedge clk);
    #1 check("rst_test_gnt", gnt[1], 1'b1);
    @(negedge clk);
    req[1] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    check("rst_resp_rvalid", rvalid[1], 1'b0);
    check("rst_resp_gnt", gnt[1], 1'b0);
    @(negedge clk);
    #1 check("rst_resp_rvalid_late", rvalid[1], 1'b0);
    rst_n[1] = 1'b1;
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 3, 2);

    repeat (3) @(negedge clk);
    #3;
    check("exp_q0_drained", exp_q0.size(), 0);
    check("exp_q1_drained", exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
